// File: rtl/ex_issue_stage.sv
// Two-stage execute front end: S1 decodes MIPS opcode/funct and drives the one-hot ALU
// from registers, S2 captures Result/Overflow for writeback. Optional: OVF_TRAP_EN.
module ex_issue_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned OP_WIDTH       = 12,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                in_opcode,
  input  logic [5:0]                in_funct,
  input  logic [4:0]                in_shamt,
  input  logic [15:0]               in_imm,
  input  logic [DATA_WIDTH-1:0]     in_rs_val,
  input  logic [DATA_WIDTH-1:0]     in_rt_val,
  input  logic [REG_ADDR_WIDTH-1:0] in_rt,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  output logic [DATA_WIDTH-1:0]     alu_A,
  output logic [DATA_WIDTH-1:0]     alu_B,
  output logic [OP_WIDTH-1:0]       alu_op,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic                      alu_overflow,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic [REG_ADDR_WIDTH-1:0] out_dest,
  output logic                      out_wen,
  output logic                      out_exc
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_NOR  = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [5:0] {
    F_SLL  = 6'h00,
    F_SRL  = 6'h02,
    F_SRA  = 6'h03,
    F_SLLV = 6'h04,
    F_SRLV = 6'h06,
    F_SRAV = 6'h07,
    F_ADD  = 6'h20,
    F_ADDU = 6'h21,
    F_SUB  = 6'h22,
    F_SUBU = 6'h23,
    F_AND  = 6'h24,
    F_OR   = 6'h25,
    F_XOR  = 6'h26,
    F_NOR  = 6'h27,
    F_SLT  = 6'h2A,
    F_SLTU = 6'h2B
  } funct_e;

  typedef enum logic [5:0] {
    OPC_RTYPE = 6'h00,
    OPC_ADDI  = 6'h08,
    OPC_ADDIU = 6'h09,
    OPC_SLTI  = 6'h0A,
    OPC_SLTIU = 6'h0B,
    OPC_ANDI  = 6'h0C,
    OPC_ORI   = 6'h0D,
    OPC_XORI  = 6'h0E,
    OPC_LUI   = 6'h0F
  } opcode_e;

  // S1 state
  logic                      s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [OP_WIDTH-1:0]       alu_op_q, alu_op_d;
  logic [REG_ADDR_WIDTH-1:0] s1_dest_q, s1_dest_d;
  logic                      s1_illegal_q, s1_illegal_d;
  logic                      s1_trapcap_q, s1_trapcap_d;

  // S2 state
  logic                      out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]     out_result_q, out_result_d;
  logic [REG_ADDR_WIDTH-1:0] out_dest_q, out_dest_d;
  logic                      out_wen_q, out_wen_d;
  logic                      out_exc_q, out_exc_d;

  // Decode results
  logic [OP_WIDTH-1:0]       dec_op;
  logic [DATA_WIDTH-1:0]     dec_a;
  logic [DATA_WIDTH-1:0]     dec_b;
  logic [REG_ADDR_WIDTH-1:0] dec_dest;
  logic                      dec_illegal;
  logic                      dec_trapcap;
  logic [DATA_WIDTH-1:0]     imm_sext;
  logic [DATA_WIDTH-1:0]     imm_zext;
  logic [DATA_WIDTH-1:0]     shamt_ext;

  logic s2_ready, s1_ready, s1_fire, s2_load;
  logic trap, cap_wen, cap_exc;

  assign s2_ready = !out_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign s1_fire  = in_valid && s1_ready;
  assign s2_load  = s1_valid_q && s2_ready;
  assign in_ready = s1_ready;

  assign imm_sext  = {{(DATA_WIDTH-16){in_imm[15]}}, in_imm};
  assign imm_zext  = {{(DATA_WIDTH-16){1'b0}}, in_imm};
  assign shamt_ext = {{(DATA_WIDTH-5){1'b0}}, in_shamt};

  always_comb begin
    dec_op      = '0;
    dec_a       = in_rs_val;
    dec_b       = in_rt_val;
    dec_dest    = in_rt;
    dec_illegal = 1'b0;
    dec_trapcap = 1'b0;
    if (in_opcode == OPC_RTYPE) begin
      dec_dest = in_rd;
      case (in_funct)
        F_ADD:  begin dec_op[OP_ADD] = 1'b1; dec_trapcap = 1'b1; end
        F_ADDU: dec_op[OP_ADD] = 1'b1;
        F_SUB:  begin dec_op[OP_SUB] = 1'b1; dec_trapcap = 1'b1; end
        F_SUBU: dec_op[OP_SUB] = 1'b1;
        F_AND:  dec_op[OP_AND] = 1'b1;
        F_OR:   dec_op[OP_OR] = 1'b1;
        F_XOR:  dec_op[OP_XOR] = 1'b1;
        F_NOR:  dec_op[OP_NOR] = 1'b1;
        F_SLT:  dec_op[OP_SLT] = 1'b1;
        F_SLTU: dec_op[OP_SLTU] = 1'b1;
        F_SLL:  begin dec_op[OP_SLL] = 1'b1; dec_a = shamt_ext; end
        F_SRL:  begin dec_op[OP_SRL] = 1'b1; dec_a = shamt_ext; end
        F_SRA:  begin dec_op[OP_SRA] = 1'b1; dec_a = shamt_ext; end
        F_SLLV: dec_op[OP_SLL] = 1'b1;
        F_SRLV: dec_op[OP_SRL] = 1'b1;
        F_SRAV: dec_op[OP_SRA] = 1'b1;
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      case (in_opcode)
        OPC_ADDI:  begin dec_op[OP_ADD] = 1'b1; dec_b = imm_sext; dec_trapcap = 1'b1; end
        OPC_ADDIU: begin dec_op[OP_ADD] = 1'b1; dec_b = imm_sext; end
        OPC_SLTI:  begin dec_op[OP_SLT] = 1'b1; dec_b = imm_sext; end
        OPC_SLTIU: begin dec_op[OP_SLTU] = 1'b1; dec_b = imm_sext; end
        OPC_ANDI:  begin dec_op[OP_AND] = 1'b1; dec_b = imm_zext; end
        OPC_ORI:   begin dec_op[OP_OR] = 1'b1; dec_b = imm_zext; end
        OPC_XORI:  begin dec_op[OP_XOR] = 1'b1; dec_b = imm_zext; end
        OPC_LUI:   begin dec_op[OP_LUI] = 1'b1; dec_b = imm_zext; dec_a = '0; end
        default:   dec_illegal = 1'b1;
      endcase
    end
  end

  // S1: load on accept; on drain without refill the op is cleared so the ALU idles.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    s1_dest_d    = s1_dest_q;
    s1_illegal_d = s1_illegal_q;
    s1_trapcap_d = s1_trapcap_q;
    if (s1_fire) begin
      s1_valid_d   = 1'b1;
      alu_a_d      = dec_a;
      alu_b_d      = dec_b;
      alu_op_d     = dec_op;
      s1_dest_d    = dec_dest;
      s1_illegal_d = dec_illegal;
      s1_trapcap_d = dec_trapcap;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
      alu_op_d   = '0;
    end
  end

`ifdef OVF_TRAP_EN
  assign trap = alu_overflow && s1_trapcap_q;
`else
  logic unused_ovf;
  assign trap       = 1'b0;
  assign unused_ovf = alu_overflow ^ s1_trapcap_q;
`endif

  assign cap_exc = s1_illegal_q || trap;
  assign cap_wen = !cap_exc && (s1_dest_q != '0);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_dest_d   = out_dest_q;
    out_wen_d    = out_wen_q;
    out_exc_d    = out_exc_q;
    if (s2_load) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_result;
      out_dest_d   = s1_dest_q;
      out_wen_d    = cap_wen;
      out_exc_d    = cap_exc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      s1_dest_q    <= '0;
      s1_illegal_q <= 1'b0;
      s1_trapcap_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_dest_q   <= '0;
      out_wen_q    <= 1'b0;
      out_exc_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      s1_dest_q    <= s1_dest_d;
      s1_illegal_q <= s1_illegal_d;
      s1_trapcap_q <= s1_trapcap_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_dest_q   <= out_dest_d;
      out_wen_q    <= out_wen_d;
      out_exc_q    <= out_exc_d;
    end
  end

  assign alu_A      = alu_a_q;
  assign alu_B      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_dest   = out_dest_q;
  assign out_wen    = out_wen_q;
  assign out_exc    = out_exc_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: behavioural ALU, instruction-level reference model and
// scoreboard queue; directed cases followed by randomized traffic with back-pressure.
module tb_ex_issue_stage;

  typedef struct packed {
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rti;
    logic [4:0]  rdi;
  } instr_t;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  dest;
    logic        wen;
    logic        exc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready;
  logic [5:0]  in_opcode, in_funct;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic [31:0] in_rs_val, in_rt_val;
  logic [4:0]  in_rt, in_rd;
  logic [31:0] alu_A, alu_B;
  logic [11:0] alu_op;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic        out_wen, out_exc;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        q[$];
  instr_t      cur;
  logic        last_acc = 1'b0;
  logic        hold_v = 1'b0;
  logic [39:0] hold_val = '0;

  ex_issue_stage #(.DATA_WIDTH(32), .OP_WIDTH(12), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_rt(in_rt), .in_rd(in_rd),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dest(out_dest), .out_wen(out_wen), .out_exc(out_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 12-bit one-hot ALU
  always_comb begin
    logic [31:0] s;
    alu_result   = '0;
    alu_overflow = 1'b0;
    s            = '0;
    case (alu_op)
      12'h001: begin s = alu_A + alu_B; alu_result = s;
                     alu_overflow = (alu_A[31] == alu_B[31]) && (s[31] != alu_A[31]); end
      12'h002: begin s = alu_A - alu_B; alu_result = s;
                     alu_overflow = (alu_A[31] != alu_B[31]) && (s[31] != alu_A[31]); end
      12'h004: alu_result = alu_A & alu_B;
      12'h008: alu_result = alu_A | alu_B;
      12'h010: alu_result = ~(alu_A | alu_B);
      12'h020: alu_result = alu_A ^ alu_B;
      12'h040: alu_result = {31'b0, $signed(alu_A) < $signed(alu_B)};
      12'h080: alu_result = {31'b0, alu_A < alu_B};
      12'h100: alu_result = alu_B << alu_A[4:0];
      12'h200: alu_result = alu_B >> alu_A[4:0];
      12'h400: alu_result = $signed(alu_B) >>> alu_A[4:0];
      12'h800: alu_result = {alu_B[15:0], 16'h0000};
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction-level expectation straight from the ISA semantics
  function automatic exp_t model(input instr_t i);
    exp_t        e;
    logic [31:0] a, b, simm, zimm, r;
    logic        ovf, cap, ill, trap;
    a = i.rs; b = i.rt;
    simm = {{16{i.imm[15]}}, i.imm};
    zimm = {16'h0000, i.imm};
    r = '0; ovf = 1'b0; cap = 1'b0; ill = 1'b0;
    if (i.opc == 6'h00) begin
      case (i.fn)
        6'h20: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); cap = 1'b1; end
        6'h21: r = a + b;
        6'h22: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); cap = 1'b1; end
        6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2A: r = {31'b0, $signed(a) < $signed(b)};
        6'h2B: r = {31'b0, a < b};
        6'h00: r = b << i.sh;
        6'h02: r = b >> i.sh;
        6'h03: r = $signed(b) >>> i.sh;
        6'h04: r = b << a[4:0];
        6'h06: r = b >> a[4:0];
        6'h07: r = $signed(b) >>> a[4:0];
        default: ill = 1'b1;
      endcase
    end else begin
      case (i.opc)
        6'h08: begin r = a + simm; ovf = (a[31] == simm[31]) && (r[31] != a[31]); cap = 1'b1; end
        6'h09: r = a + simm;
        6'h0A: r = {31'b0, $signed(a) < $signed(simm)};
        6'h0B: r = {31'b0, a < simm};
        6'h0C: r = a & zimm;
        6'h0D: r = a | zimm;
        6'h0E: r = a ^ zimm;
        6'h0F: r = {i.imm, 16'h0000};
        default: ill = 1'b1;
      endcase
    end
`ifdef OVF_TRAP_EN
    trap = ovf && cap;
`else
    trap = 1'b0;
`endif
    e.res  = r;
    e.dest = (i.opc == 6'h00) ? i.rdi : i.rti;
    e.exc  = ill || trap;
    e.wen  = !ill && !trap && (e.dest != 5'd0);
    return e;
  endfunction

  function automatic instr_t mk(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                                input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [4:0] rti, input logic [4:0] rdi);
    instr_t i;
    i.opc = opc; i.fn = fn; i.sh = sh; i.imm = imm;
    i.rs = rs; i.rt = rt; i.rti = rti; i.rdi = rdi;
    return i;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h00000001;
      default: return $urandom();
    endcase
  endfunction

  function automatic instr_t rand_instr();
    logic [5:0] opcs[27] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                             6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3F, 6'h23};
    logic [5:0] fns[17]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                             6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h01};
    int unsigned k;
    logic [5:0]  fn;
    k  = $urandom_range(0, 26);
    fn = (k < 17) ? fns[k] : 6'($urandom());
    return mk(opcs[k], fn, 5'($urandom()), 16'($urandom()), rnd_val(), rnd_val(),
              5'($urandom()), 5'($urandom()));
  endfunction

  task automatic monitor();
    logic acc, cons;
    exp_t e;
    acc  = in_valid && in_ready && !rst;
    cons = out_valid && out_ready && !rst;
    if (hold_v && !rst)
      check("hold", 64'({out_valid, out_result, out_dest, out_wen, out_exc}), 64'(hold_val));
    hold_v   = out_valid && !out_ready && !rst;
    hold_val = {out_valid, out_result, out_dest, out_wen, out_exc};
    if (rst) q.delete();
    if (cons) begin
      if (q.size() == 0) begin
        check("wb_extra", 64'(out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        check("wb", 64'({out_result, out_dest, out_wen, out_exc}), 64'(e));
      end
    end
    if (acc) q.push_back(model(cur));
    last_acc = acc;
  endtask

  task automatic step(input logic v, input instr_t ins, input logic ordy, input logic r);
    @(posedge clk);
    #1;
    rst = r; in_valid = v; cur = ins; out_ready = ordy;
    in_opcode = ins.opc; in_funct = ins.fn; in_shamt = ins.sh; in_imm = ins.imm;
    in_rs_val = ins.rs; in_rt_val = ins.rt; in_rt = ins.rti; in_rd = ins.rdi;
    @(negedge clk);
    monitor();
  endtask

  task automatic offer(input instr_t ins);
    int unsigned n = 0;
    do begin
      step(1'b1, ins, 1'b1, 1'b0);
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) check("offer_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, ordy, 1'b0);
  endtask

  initial begin
    instr_t      ins;
    instr_t      bp[4];
    logic        v;
    int unsigned k;
    int unsigned n;
    logic        exc_exp;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cur = '0;
    in_opcode = '0; in_funct = '0; in_shamt = '0; in_imm = '0;
    in_rs_val = '0; in_rt_val = '0; in_rt = '0; in_rd = '0;

    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'd0);
    check("rst_alu_A", 64'(alu_A), 64'd0);
    check("rst_alu_B", 64'(alu_B), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_dest", 64'(out_dest), 64'd0);
    check("rst_out_wen_exc", 64'({out_wen, out_exc}), 64'd0);

    // addu rd=3 rs=5 rt=7
    offer(mk(6'h00, 6'h21, 5'd0, 16'h0, 32'd5, 32'd7, 5'd7, 5'd3));
    idle(1'b1);
    check("addu_alu_op", 64'(alu_op), 64'h001);
    check("addu_alu_AB", 64'({alu_A, alu_B}), {32'd5, 32'd7});
    idle(1'b1);
    check("addu_latency", 64'({out_valid, out_result}), 64'({1'b1, 32'd12}));

    // sll rd=4 rt=1 shamt=31
    offer(mk(6'h00, 6'h00, 5'd31, 16'h0, 32'h12345678, 32'd1, 5'd1, 5'd4));
    idle(1'b1);
    check("sll_alu_op", 64'(alu_op), 64'h100);
    check("sll_alu_A", 64'(alu_A), 64'd31);
    idle(1'b1);
    check("sll_result", 64'(out_result), 64'h80000000);

    // lui rt=2 imm=0x1234
    offer(mk(6'h0F, 6'h00, 5'd0, 16'h1234, 32'hDEADBEEF, 32'd0, 5'd2, 5'd0));
    idle(1'b1);
    check("lui_alu_op", 64'(alu_op), 64'h800);
    check("lui_alu_A", 64'(alu_A), 64'd0);
    idle(1'b1);

    // sltiu rt=6 rs=1 imm=0xFFFF
    offer(mk(6'h0B, 6'h00, 5'd0, 16'hFFFF, 32'd1, 32'd0, 5'd6, 5'd0));
    idle(1'b1);
    check("sltiu_alu_B", 64'(alu_B), 64'hFFFFFFFF);
    idle(1'b1);
    check("sltiu_result", 64'(out_result), 64'd1);

    // add overflow
    offer(mk(6'h00, 6'h20, 5'd0, 16'h0, 32'h7FFFFFFF, 32'd1, 5'd1, 5'd9));
    idle(1'b1);
    idle(1'b1);
`ifdef OVF_TRAP_EN
    exc_exp = 1'b1;
`else
    exc_exp = 1'b0;
`endif
    check("add_ovf_exc", 64'(out_exc), 64'(exc_exp));
    check("add_ovf_wen", 64'(out_wen), 64'(!exc_exp));
    idle(1'b1);

    // Back-to-back with writeback stalled for 3 cycles
    bp[0] = mk(6'h00, 6'h21, 5'd0, 16'h0, 32'd10, 32'd20, 5'd0, 5'd11);
    bp[1] = mk(6'h0D, 6'h00, 5'd0, 16'h00F0, 32'h0F, 32'd0, 5'd12, 5'd0);
    bp[2] = mk(6'h3F, 6'h00, 5'd0, 16'h0, 32'd1, 32'd2, 5'd13, 5'd0);
    bp[3] = mk(6'h00, 6'h23, 5'd0, 16'h0, 32'd3, 32'd5, 5'd0, 5'd14);
    k = 0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, bp[k], 1'b0, 1'b0);
      if (last_acc) k++;
    end
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_accepted", 64'(k), 64'd2);
    n = 0;
    while (k < 4 && n < 20) begin
      step(1'b1, bp[k], 1'b1, 1'b0);
      if (last_acc) k++;
      n++;
    end
    check("bp_all_accepted", 64'(k), 64'd4);
    for (int c = 0; c < 4; c++) idle(1'b1);
    check("bp_drained", 64'(q.size()), 64'd0);

    // Reset while two ops are in flight
    offer(bp[0]);
    step(1'b1, bp[1], 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_alu_op", 64'(alu_op), 64'd0);

    // Randomized traffic
    v = 1'b0;
    ins = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!(v && !last_acc)) begin
        v   = ($urandom_range(0, 3) != 0);
        ins = rand_instr();
      end
      step(v, ins, ($urandom_range(0, 2) != 0), ($urandom_range(0, 199) == 0));
    end
    for (int c = 0; c < 6; c++) idle(1'b1);
    check("final_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
